// File: rtl/decode_stage_hz.sv
// RV32I/RV32E decode stage with ID/EX register, valid/ready handshake, load-use
// bubble insertion and a write-first WB->D regfile bypass.
package decode_stage_hz_pkg;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_AND    = 4'd2,
    ALU_OR     = 4'd3,
    ALU_XOR    = 4'd4,
    ALU_SLT    = 4'd5,
    ALU_SLTU   = 4'd6,
    ALU_SLL    = 4'd7,
    ALU_SRL    = 4'd8,
    ALU_SRA    = 4'd9,
    ALU_LUI    = 4'd10,
    ALU_UNUSED = 4'd15
  } alu_op_t;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_J = 3'd3,
    IMM_U = 3'd4
  } imm_src_t;

endpackage

module decode_stage_hz_ctrl
  import decode_stage_hz_pkg::*;
(
  input  logic [6:0] op_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  output logic       reg_write_o,
  output logic       mem_write_o,
  output logic       jump_o,
  output logic       branch_o,
  output logic       alu_src_o,
  output logic [1:0] result_src_o,
  output imm_src_t   imm_src_o,
  output alu_op_t    alu_ctrl_o,
  output logic [2:0] store_type_o
);

  // Register-register and register-immediate ops share funct3; only R-type uses bit 30 for SUB.
  function automatic alu_op_t alu_from_funct(input logic [2:0] f3, input logic f7b5, input logic is_r);
    alu_op_t op;
    case (f3)
      3'b000:  op = (is_r && f7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = f7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      3'b111:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

  // Main opcode decoder.
  always_comb begin
    reg_write_o  = 1'b0;
    mem_write_o  = 1'b0;
    jump_o       = 1'b0;
    branch_o     = 1'b0;
    alu_src_o    = 1'b0;
    result_src_o = 2'b00;
    imm_src_o    = IMM_I;
    alu_ctrl_o   = ALU_UNUSED;
    store_type_o = 3'b010;
    case (op_i)
      7'b0000011: begin
        reg_write_o  = 1'b1;
        alu_src_o    = 1'b1;
        result_src_o = 2'b01;
        alu_ctrl_o   = ALU_ADD;
      end
      7'b0100011: begin
        mem_write_o  = 1'b1;
        alu_src_o    = 1'b1;
        imm_src_o    = IMM_S;
        alu_ctrl_o   = ALU_ADD;
        store_type_o = funct3_i;
      end
      7'b0110011: begin
        reg_write_o = 1'b1;
        alu_ctrl_o  = alu_from_funct(funct3_i, funct7b5_i, 1'b1);
      end
      7'b0010011: begin
        reg_write_o = 1'b1;
        alu_src_o   = 1'b1;
        alu_ctrl_o  = alu_from_funct(funct3_i, funct7b5_i, 1'b0);
      end
      7'b1100011: begin
        branch_o   = 1'b1;
        imm_src_o  = IMM_B;
        alu_ctrl_o = ALU_SUB;
      end
      7'b1101111: begin
        reg_write_o  = 1'b1;
        jump_o       = 1'b1;
        result_src_o = 2'b10;
        imm_src_o    = IMM_J;
        alu_ctrl_o   = ALU_ADD;
      end
      7'b0110111: begin
        reg_write_o = 1'b1;
        alu_src_o   = 1'b1;
        imm_src_o   = IMM_U;
        alu_ctrl_o  = ALU_LUI;
      end
      default: begin
        reg_write_o = 1'b0;
      end
    endcase
  end

endmodule

module decode_stage_hz_ext
  import decode_stage_hz_pkg::*;
(
  input  logic [31:7] instr_i,
  input  imm_src_t    imm_src_i,
  output logic [31:0] imm_ext_o
);

  // Immediate reassembly and sign extension per instruction format.
  always_comb begin
    imm_ext_o = 32'd0;
    case (imm_src_i)
      IMM_I:   imm_ext_o = {{20{instr_i[31]}}, instr_i[31:20]};
      IMM_S:   imm_ext_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      IMM_B:   imm_ext_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
      IMM_J:   imm_ext_o = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
      IMM_U:   imm_ext_o = {instr_i[31:12], 12'd0};
      default: imm_ext_o = 32'd0;
    endcase
  end

endmodule

module decode_stage_hz
  import decode_stage_hz_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int PC_WIDTH   = 11,
  parameter int WB_BYPASS  = 1,
  parameter int PERF_W     = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_valid_d,
  output logic                  o_ready_d,
  input  logic [DATA_WIDTH-1:0] i_instr_d,
  input  logic [PC_WIDTH-1:0]   i_pc_d,
  input  logic [PC_WIDTH-1:0]   i_pc4_d,
  input  logic                  i_stall_e,
  input  logic                  i_flush_e,
  input  logic                  i_reg_write_w,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr_w,
  input  logic [DATA_WIDTH-1:0] i_result_w,
  input  logic                  i_zero_e,
  output logic                  o_valid_e,
  output logic                  o_regwrite_e,
  output logic                  o_memwrite_e,
  output logic                  o_jump_e,
  output logic                  o_branch_e,
  output logic                  o_alusrc_e,
  output logic [1:0]            o_resultsrc_e,
  output alu_op_t               o_aluctrl_e,
  output logic [2:0]            o_storetype_e,
  output logic [DATA_WIDTH-1:0] o_rs1_data_e,
  output logic [DATA_WIDTH-1:0] o_rs2_data_e,
  output logic [DATA_WIDTH-1:0] o_immext_e,
  output logic [ADDR_WIDTH-1:0] o_rs1_addr_e,
  output logic [ADDR_WIDTH-1:0] o_rs2_addr_e,
  output logic [ADDR_WIDTH-1:0] o_rd_addr_e,
  output logic [PC_WIDTH-1:0]   o_pc_e,
  output logic [PC_WIDTH-1:0]   o_pc4_e,
  output logic                  o_pcsrc_e,
  output logic                  o_lduse_stall,
  output logic [PERF_W-1:0]     o_bubble_cnt
);

  localparam int NUM_REGS = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] REG_ZERO = {ADDR_WIDTH{1'b0}};
  localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};
  localparam logic [PERF_W-1:0] CNT_MAX = {PERF_W{1'b1}};

  typedef struct packed {
    logic                  valid;
    logic                  reg_write;
    logic                  mem_write;
    logic                  jump;
    logic                  branch;
    logic                  alu_src;
    logic [1:0]            result_src;
    alu_op_t               alu_ctrl;
    logic [2:0]            store_type;
    logic [DATA_WIDTH-1:0] rs1_data;
    logic [DATA_WIDTH-1:0] rs2_data;
    logic [DATA_WIDTH-1:0] imm_ext;
    logic [ADDR_WIDTH-1:0] rs1_addr;
    logic [ADDR_WIDTH-1:0] rs2_addr;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [PC_WIDTH-1:0]   pc;
    logic [PC_WIDTH-1:0]   pc4;
  } idex_t;

  localparam idex_t IDEX_BUBBLE = '{alu_ctrl: ALU_UNUSED, store_type: 3'b010, default: '0};

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  idex_t                 idex_q, idex_d, idex_load_s;
  logic [PERF_W-1:0]     cnt_q, cnt_d;

  logic [ADDR_WIDTH-1:0] rs1_s, rs2_s, rd_s;
  logic [DATA_WIDTH-1:0] rs1_data_s, rs2_data_s, imm_ext_s;
  logic [31:0]           imm32_s;
  logic                  byp1_s, byp2_s, lduse_s;
  logic                  reg_write_s, mem_write_s, jump_s, branch_s, alu_src_s;
  logic [1:0]            result_src_s;
  imm_src_t              imm_src_s;
  alu_op_t               alu_ctrl_s;
  logic [2:0]            store_type_s;

  // With ADDR_WIDTH=4 the top address bit of each field is dropped, so x16..x31 alias x0..x15.
  assign rs1_s = i_instr_d[15 +: ADDR_WIDTH];
  assign rs2_s = i_instr_d[20 +: ADDR_WIDTH];
  assign rd_s  = i_instr_d[7 +: ADDR_WIDTH];

  decode_stage_hz_ctrl u_ctrl (
    .op_i         (i_instr_d[6:0]),
    .funct3_i     (i_instr_d[14:12]),
    .funct7b5_i   (i_instr_d[30]),
    .reg_write_o  (reg_write_s),
    .mem_write_o  (mem_write_s),
    .jump_o       (jump_s),
    .branch_o     (branch_s),
    .alu_src_o    (alu_src_s),
    .result_src_o (result_src_s),
    .imm_src_o    (imm_src_s),
    .alu_ctrl_o   (alu_ctrl_s),
    .store_type_o (store_type_s)
  );

  decode_stage_hz_ext u_ext (
    .instr_i   (i_instr_d[31:7]),
    .imm_src_i (imm_src_s),
    .imm_ext_o (imm32_s)
  );

  assign imm_ext_s = DATA_WIDTH'(imm32_s);

  // Write-first bypass: a WB write in the same cycle wins over the stored value.
  assign byp1_s = (WB_BYPASS != 0) && i_reg_write_w && (i_rd_addr_w == rs1_s);
  assign byp2_s = (WB_BYPASS != 0) && i_reg_write_w && (i_rd_addr_w == rs2_s);
  assign rs1_data_s = (rs1_s == REG_ZERO) ? DATA_ZERO : (byp1_s ? i_result_w : regs_q[rs1_s]);
  assign rs2_data_s = (rs2_s == REG_ZERO) ? DATA_ZERO : (byp2_s ? i_result_w : regs_q[rs2_s]);

  // Register file write port; x0 is never written.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= DATA_ZERO;
      end
    end else if (i_reg_write_w && (i_rd_addr_w != REG_ZERO)) begin
      regs_q[i_rd_addr_w] <= i_result_w;
    end
  end

  // rs2 is compared even for formats without an rs2 field; a spurious bubble is harmless.
  assign lduse_s = i_valid_d && idex_q.valid && (idex_q.result_src == 2'b01)
                 && (idex_q.rd_addr != REG_ZERO)
                 && ((rs1_s == idex_q.rd_addr) || (rs2_s == idex_q.rd_addr));

  assign o_ready_d     = !i_stall_e && !lduse_s;
  assign o_lduse_stall = lduse_s;

  // Fields captured into ID/EX when a decoded instruction advances.
  always_comb begin
    idex_load_s            = IDEX_BUBBLE;
    idex_load_s.valid      = 1'b1;
    idex_load_s.reg_write  = reg_write_s;
    idex_load_s.mem_write  = mem_write_s;
    idex_load_s.jump       = jump_s;
    idex_load_s.branch     = branch_s;
    idex_load_s.alu_src    = alu_src_s;
    idex_load_s.result_src = result_src_s;
    idex_load_s.alu_ctrl   = alu_ctrl_s;
    idex_load_s.store_type = store_type_s;
    idex_load_s.rs1_data   = rs1_data_s;
    idex_load_s.rs2_data   = rs2_data_s;
    idex_load_s.imm_ext    = imm_ext_s;
    idex_load_s.rs1_addr   = rs1_s;
    idex_load_s.rs2_addr   = rs2_s;
    idex_load_s.rd_addr    = rd_s;
    idex_load_s.pc         = i_pc_d;
    idex_load_s.pc4        = i_pc4_d;
  end

  // ID/EX next state: hold on EX stall, otherwise bubble on flush, load-use or empty D.
  always_comb begin
    idex_d = idex_q;
    if (i_stall_e) begin
      idex_d = idex_q;
    end else if (i_flush_e || lduse_s || !i_valid_d) begin
      idex_d = IDEX_BUBBLE;
    end else begin
      idex_d = idex_load_s;
    end
  end

  // ID/EX pipeline register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      idex_q <= IDEX_BUBBLE;
    end else begin
      idex_q <= idex_d;
    end
  end

  // A bubble is counted only when it actually enters EX.
  always_comb begin
    cnt_d = cnt_q;
    if (lduse_s && !i_stall_e && !i_flush_e && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + PERF_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Saturating load-use bubble counter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= {PERF_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_bubble_cnt  = cnt_q;
  assign o_valid_e     = idex_q.valid;
  assign o_regwrite_e  = idex_q.reg_write;
  assign o_memwrite_e  = idex_q.mem_write;
  assign o_jump_e      = idex_q.jump;
  assign o_branch_e    = idex_q.branch;
  assign o_alusrc_e    = idex_q.alu_src;
  assign o_resultsrc_e = idex_q.result_src;
  assign o_aluctrl_e   = idex_q.alu_ctrl;
  assign o_storetype_e = idex_q.store_type;
  assign o_rs1_data_e  = idex_q.rs1_data;
  assign o_rs2_data_e  = idex_q.rs2_data;
  assign o_immext_e    = idex_q.imm_ext;
  assign o_rs1_addr_e  = idex_q.rs1_addr;
  assign o_rs2_addr_e  = idex_q.rs2_addr;
  assign o_rd_addr_e   = idex_q.rd_addr;
  assign o_pc_e        = idex_q.pc;
  assign o_pc4_e       = idex_q.pc4;
  assign o_pcsrc_e     = idex_q.valid && ((idex_q.branch && i_zero_e) || idex_q.jump);

endmodule
